// File: rtl/pc_packer.sv
// -----------------------------------------------------------------------------
// pc_packer
// Upstream (FPGA-to-PC) word builder. Merges BD output words, config-register
// readback responses and (optionally) heartbeat timestamps into one stream of
// NPCout-bit words. The top 3 bits of every word carry a type code:
//   000 BD word      payload = bd_in_data
//   001 readback     payload = {addr, conf_reg_in[addr]}  (addr >= Nreg -> data 0)
//   010 heartbeat lo payload = time[20:0]
//   011 heartbeat hi payload = time[41:21]
// Payloads are right-aligned and zero-padded.
//
// Optional feature macro: PC_PACKER_HEARTBEAT_EN
//   defined   : 42-bit time counter, tick generator, heartbeat pair emission
//   undefined : pure BD/RB round-robin, hb_dropped tied 0, HB_PERIOD unused
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous active-low reset
//   bd_in_valid   in   BD word available
//   bd_in_data    in   BD word
//   bd_in_ready   out  BD word accepted this cycle (combinational)
//   rb_req_valid  in   readback request
//   rb_req_addr   in   register index to read
//   rb_req_ready  out  request accepted this cycle (combinational)
//   conf_reg_in   in   live register contents [Nreg-1:0][Nconf-1:0]
//   pc_out_valid  out  output word valid
//   pc_out_data   out  output word
//   pc_out_ready  in   downstream accepts
//   hb_dropped    out  one-cycle pulse when a heartbeat tick is discarded
// -----------------------------------------------------------------------------
module pc_packer #(
    parameter int NPCout    = 24,
    parameter int NBDdata   = 21,
    parameter int Nconf     = 16,
    parameter int Nreg      = 32,
    parameter int HB_PERIOD = 1000000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            bd_in_valid,
    input  logic [NBDdata-1:0]              bd_in_data,
    output logic                            bd_in_ready,
    input  logic                            rb_req_valid,
    input  logic [$clog2(Nreg)-1:0]         rb_req_addr,
    output logic                            rb_req_ready,
    input  logic [Nreg-1:0][Nconf-1:0]      conf_reg_in,
    output logic                            pc_out_valid,
    output logic [NPCout-1:0]               pc_out_data,
    input  logic                            pc_out_ready,
    output logic                            hb_dropped
);

    localparam int AW = $clog2(Nreg);
    localparam int PW = NPCout - 3;

    localparam logic [2:0] CODE_BD  = 3'b000;
    localparam logic [2:0] CODE_RB  = 3'b001;
    localparam logic [2:0] CODE_HBL = 3'b010;
    localparam logic [2:0] CODE_HBH = 3'b011;

    typedef enum logic [2:0] {
        GNT_NONE = 3'd0,
        GNT_BD   = 3'd1,
        GNT_RB   = 3'd2,
        GNT_HBL  = 3'd3,
        GNT_HBH  = 3'd4
    } grant_t;

    generate
        if (NBDdata > NPCout - 3) begin : g_chk_bd
            $error("pc_packer: NBDdata must be <= NPCout-3");
        end
        if (AW + Nconf > NPCout - 3) begin : g_chk_rb
            $error("pc_packer: $clog2(Nreg)+Nconf must be <= NPCout-3");
        end
        if (HB_PERIOD < 1) begin : g_chk_hb
            $error("pc_packer: HB_PERIOD must be >= 1");
        end
    endgenerate

    logic              r_pc_out_valid;
    logic [NPCout-1:0] r_pc_out_data;
    logic              r_last_grant_rb;
    logic              w_load;
    grant_t            w_rr_grant;
    grant_t            w_grant;
    logic [Nconf-1:0]  w_rb_data;
    logic [PW-1:0]     w_payload;
    logic [2:0]        w_code;

    assign w_load       = !r_pc_out_valid || pc_out_ready;
    assign bd_in_ready  = w_load && (w_grant == GNT_BD);
    assign rb_req_ready = w_load && (w_grant == GNT_RB);
    assign pc_out_valid = r_pc_out_valid;
    assign pc_out_data  = r_pc_out_data;

    // Round-robin choice between BD and RB: on contention the one not served last wins.
    always_comb begin
        w_rr_grant = GNT_NONE;
        if (bd_in_valid && rb_req_valid) begin
            if (r_last_grant_rb) begin
                w_rr_grant = GNT_BD;
            end else begin
                w_rr_grant = GNT_RB;
            end
        end else if (bd_in_valid) begin
            w_rr_grant = GNT_BD;
        end else if (rb_req_valid) begin
            w_rr_grant = GNT_RB;
        end else begin
            w_rr_grant = GNT_NONE;
        end
    end

`ifdef PC_PACKER_HEARTBEAT_EN
    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_HB_HI = 1'b1
    } state_t;

    // HB_PERIOD of 1 degenerates to a tick every cycle with a 1-bit counter.
    localparam int             TW        = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(HB_PERIOD - 1);

    generate
        if (PW < 21) begin : g_chk_hbw
            $error("pc_packer: heartbeat halves need NPCout-3 >= 21");
        end
    endgenerate

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic [41:0]   r_time;
    logic [41:0]   r_hb_time;
    logic [20:0]   r_hb_hi_half;
    logic          r_hb_pending;
    logic          r_hb_dropped;
    logic          w_tick;
    logic          w_hb_low_load;

    assign w_tick        = (r_tick_cnt == TICK_LAST);
    assign w_hb_low_load = w_load && (w_grant == GNT_HBL);
    assign hb_dropped    = r_hb_dropped;

    // Arbiter next state / grant: heartbeat low word pre-empts BD/RB, high word follows it.
    always_comb begin
        w_grant     = GNT_NONE;
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB: begin
                if (r_hb_pending) begin
                    w_grant = GNT_HBL;
                    if (w_load) begin
                        w_state_nxt = ST_HB_HI;
                    end else begin
                        w_state_nxt = ST_ARB;
                    end
                end else begin
                    w_grant     = w_rr_grant;
                    w_state_nxt = ST_ARB;
                end
            end
            ST_HB_HI: begin
                w_grant = GNT_HBH;
                if (w_load) begin
                    w_state_nxt = ST_ARB;
                end else begin
                    w_state_nxt = ST_HB_HI;
                end
            end
            default: begin
                w_grant     = GNT_NONE;
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Free-running 42-bit time counter and HB_PERIOD tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_time     <= 42'd0;
            r_tick_cnt <= '0;
        end else begin
            r_time <= r_time + 42'd1;
            if (w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
            end
        end
    end

    // Heartbeat pending flag, timestamp capture and drop pulse. The high half is
    // latched when the low word goes out so a new capture cannot tear the pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hb_pending <= 1'b0;
            r_hb_time    <= 42'd0;
            r_hb_hi_half <= 21'd0;
            r_hb_dropped <= 1'b0;
        end else begin
            r_hb_dropped <= 1'b0;
            if (w_hb_low_load) begin
                r_hb_hi_half <= r_hb_time[41:21];
            end
            if (w_tick && (!r_hb_pending || w_hb_low_load)) begin
                r_hb_pending <= 1'b1;
                r_hb_time    <= r_time;
            end else if (w_tick) begin
                r_hb_dropped <= 1'b1;
            end else if (w_hb_low_load) begin
                r_hb_pending <= 1'b0;
            end
        end
    end
`else
    assign w_grant    = w_rr_grant;
    assign hb_dropped = 1'b0;
`endif

    // Readback data lookup; out-of-range addresses read as zero.
    always_comb begin
        w_rb_data = '0;
        if (int'(rb_req_addr) < Nreg) begin
            w_rb_data = conf_reg_in[rb_req_addr];
        end else begin
            w_rb_data = '0;
        end
    end

    // Type code and right-aligned payload for the granted source.
    always_comb begin
        w_code    = CODE_BD;
        w_payload = '0;
        case (w_grant)
            GNT_BD: begin
                w_code                   = CODE_BD;
                w_payload[NBDdata-1:0]   = bd_in_data;
            end
            GNT_RB: begin
                w_code                   = CODE_RB;
                w_payload[AW+Nconf-1:0]  = {rb_req_addr, w_rb_data};
            end
`ifdef PC_PACKER_HEARTBEAT_EN
            GNT_HBL: begin
                w_code          = CODE_HBL;
                w_payload[20:0] = r_hb_time[20:0];
            end
            GNT_HBH: begin
                w_code          = CODE_HBH;
                w_payload[20:0] = r_hb_hi_half;
            end
`endif
            default: begin
                w_code    = CODE_BD;
                w_payload = '0;
            end
        endcase
    end

    // Output register: loads when empty or draining, holds under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_out_valid <= 1'b0;
            r_pc_out_data  <= '0;
        end else if (w_load) begin
            if (w_grant != GNT_NONE) begin
                r_pc_out_valid <= 1'b1;
                r_pc_out_data  <= {w_code, w_payload};
            end else begin
                r_pc_out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer: remembers whether RB got the last BD/RB grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant_rb <= 1'b1;
        end else if (w_load && (w_grant == GNT_BD)) begin
            r_last_grant_rb <= 1'b0;
        end else if (w_load && (w_grant == GNT_RB)) begin
            r_last_grant_rb <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_packer.sv
`timescale 1ns/1ps
module tb_pc_packer;

    localparam int NPCout  = 24;
    localparam int NBDdata = 21;
    localparam int Nconf   = 16;
    localparam int Nreg    = 32;
    localparam int HB      = 100;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        bd_in_valid;
    logic [NBDdata-1:0]          bd_in_data;
    logic                        bd_in_ready;
    logic                        rb_req_valid;
    logic [$clog2(Nreg)-1:0]     rb_req_addr;
    logic                        rb_req_ready;
    logic [Nreg-1:0][Nconf-1:0]  conf_reg_in;
    logic                        pc_out_valid;
    logic [NPCout-1:0]           pc_out_data;
    logic                        pc_out_ready;
    logic                        hb_dropped;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_packer #(
        .NPCout(NPCout), .NBDdata(NBDdata), .Nconf(Nconf), .Nreg(Nreg), .HB_PERIOD(HB)
    ) dut (
        .clk(clk), .reset(reset),
        .bd_in_valid(bd_in_valid), .bd_in_data(bd_in_data), .bd_in_ready(bd_in_ready),
        .rb_req_valid(rb_req_valid), .rb_req_addr(rb_req_addr), .rb_req_ready(rb_req_ready),
        .conf_reg_in(conf_reg_in),
        .pc_out_valid(pc_out_valid), .pc_out_data(pc_out_data), .pc_out_ready(pc_out_ready),
        .hb_dropped(hb_dropped)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

`ifdef PC_PACKER_HEARTBEAT_EN
    logic [20:0] lo_part;
    logic [41:0] val;
    logic [41:0] prev_val;
    int          pairs;
    int          drops;
    bit          found;
`endif

    initial begin
        reset        = 1'b0;
        bd_in_valid  = 1'b0;
        bd_in_data   = '0;
        rb_req_valid = 1'b0;
        rb_req_addr  = '0;
        pc_out_ready = 1'b0;
        for (int k = 0; k < Nreg; k++) conf_reg_in[k] = 16'h1000 + 16'(k);
        conf_reg_in[5] = 16'hBEEF;

        // Reset state
        #12;
        chk("rst_valid", pc_out_valid, 1'b0);
        chk("rst_data", pc_out_data, 24'h000000);
        chk("rst_hbdrop", hb_dropped, 1'b0);
        chk("rst_bdrdy", bd_in_ready, 1'b0);
        chk("rst_rbrdy", rb_req_ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // BD only, 1-cycle latency, then 10 back-to-back words
        bd_in_valid  = 1'b1;
        bd_in_data   = 21'h1ABCDE;
        pc_out_ready = 1'b1;
        #1;
        chk("bd_ready", bd_in_ready, 1'b1);
        step();
        chk("bd_valid", pc_out_valid, 1'b1);
        chk("bd_data", pc_out_data, 24'h1ABCDE);
        for (int i = 0; i < 10; i++) begin
            bd_in_data = 21'h000100 + 21'(i);
            step();
            chk("b2b_valid", pc_out_valid, 1'b1);
            chk("b2b_data", pc_out_data, 24'h000100 + 24'(i));
        end
        bd_in_valid = 1'b0;
        step();
        chk("bd_idle", pc_out_valid, 1'b0);

        // Readback
        rb_req_valid = 1'b1;
        rb_req_addr  = 5'd5;
        #1;
        chk("rb_ready", rb_req_ready, 1'b1);
        chk("rb_bdrdy", bd_in_ready, 1'b0);
        step();
        chk("rb5_valid", pc_out_valid, 1'b1);
        chk("rb5_data", pc_out_data, 24'h25BEEF);
        rb_req_addr    = 5'd31;
        conf_reg_in[5] = 16'h0000;
        step();
        chk("rb31_data", pc_out_data, 24'h3F101F);
        rb_req_valid   = 1'b0;
        conf_reg_in[5] = 16'hBEEF;
        step();
        chk("rb_idle", pc_out_valid, 1'b0);

        // Contention from reset release: BD first, then alternating
        rst_pulse();
        bd_in_valid  = 1'b1;
        bd_in_data   = 21'h0AAAA0;
        rb_req_valid = 1'b1;
        rb_req_addr  = 5'd3;
        #1;
        chk("cont_bdrdy0", bd_in_ready, 1'b1);
        chk("cont_rbrdy0", rb_req_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cont_bd", pc_out_data, 24'h0AAAA0);
            step();
            chk("cont_rb", pc_out_data, 24'h231003);
        end
        bd_in_valid  = 1'b0;
        rb_req_valid = 1'b0;
        step();

        // Backpressure: word holds, no readies, no loss or duplication
        bd_in_valid = 1'b1;
        bd_in_data  = 21'h011111;
        step();
        chk("bp_w0", pc_out_data, 24'h011111);
        bd_in_data   = 21'h022222;
        rb_req_valid = 1'b1;
        rb_req_addr  = 5'd7;
        pc_out_ready = 1'b0;
        #1;
        chk("bp_bdrdy", bd_in_ready, 1'b0);
        chk("bp_rbrdy", rb_req_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", pc_out_valid, 1'b1);
            chk("bp_hold_data", pc_out_data, 24'h011111);
            chk("bp_hold_bdrdy", bd_in_ready, 1'b0);
            chk("bp_hold_rbrdy", rb_req_ready, 1'b0);
        end
        pc_out_ready = 1'b1;
        #1;
        chk("bp_rel_rbrdy", rb_req_ready, 1'b1);
        chk("bp_rel_bdrdy", bd_in_ready, 1'b0);
        step();
        chk("bp_rb", pc_out_data, 24'h271007);
        rb_req_valid = 1'b0;
        step();
        chk("bp_w1", pc_out_data, 24'h022222);
        bd_in_data = 21'h033333;
        step();
        chk("bp_w2", pc_out_data, 24'h033333);
        bd_in_valid = 1'b0;
        step();
        chk("bp_idle", pc_out_valid, 1'b0);
        chk("bp_hbdrop", hb_dropped, 1'b0);

        // Reset while a word is held
        bd_in_valid  = 1'b1;
        bd_in_data   = 21'h155555;
        pc_out_ready = 1'b0;
        step();
        chk("mr_valid", pc_out_valid, 1'b1);
        chk("mr_data", pc_out_data, 24'h155555);
        reset = 1'b0;
        #1;
        chk("mr_async_valid", pc_out_valid, 1'b0);
        chk("mr_async_data", pc_out_data, 24'h000000);
        @(negedge clk);
        reset        = 1'b1;
        pc_out_ready = 1'b1;
        step();
        chk("mr_first_valid", pc_out_valid, 1'b1);
        chk("mr_first_data", pc_out_data, 24'h155555);
        bd_in_valid = 1'b0;
        step();

`ifdef PC_PACKER_HEARTBEAT_EN
        // Heartbeat pairs with BD continuously valid
        rst_pulse();
        bd_in_valid  = 1'b1;
        bd_in_data   = 21'h0B0B0B;
        pc_out_ready = 1'b1;
        pairs        = 0;
        prev_val     = 42'd0;
        for (int c = 0; c < 340; c++) begin
            step();
            if (pc_out_valid && pc_out_data[23:21] == 3'b010) begin
                lo_part = pc_out_data[20:0];
                step();
                chk("hb_hi_code", pc_out_data[23:21], 3'b011);
                val = {pc_out_data[20:0], lo_part};
                if (pairs == 0) begin
                    chk("hb_first_val", (val == 42'd99) || (val == 42'd100), 1'b1);
                end else begin
                    chk("hb_delta", val - prev_val, 42'd100);
                end
                prev_val = val;
                pairs++;
            end else begin
                chk("hb_no_lone_hi", pc_out_data[23:21] == 3'b011, 1'b0);
            end
        end
        chk("hb_pairs", pairs, 3);

        // Wait for the next high word, then stall 250 cycles
        found = 1'b0;
        for (int c = 0; c < 150 && !found; c++) begin
            step();
            if (pc_out_valid && pc_out_data[23:21] == 3'b011) found = 1'b1;
        end
        chk("hb_wait_hi", found, 1'b1);
        pc_out_ready = 1'b0;
        drops        = 0;
        for (int c = 0; c < 250; c++) begin
            step();
            if (hb_dropped) drops++;
        end
        chk("hb_drop_count", drops, 1);
        pc_out_ready = 1'b1;
        step();
        chk("hb_post_lo_code", pc_out_data[23:21], 3'b010);
        lo_part = pc_out_data[20:0];
        step();
        chk("hb_post_hi_code", pc_out_data[23:21], 3'b011);
        chk("hb_post_val", {pc_out_data[20:0], lo_part}, prev_val + 42'd200);

        // Reset while the high word is pending
        found = 1'b0;
        for (int c = 0; c < 150 && !found; c++) begin
            step();
            if (pc_out_valid && pc_out_data[23:21] == 3'b010) found = 1'b1;
        end
        chk("hb_wait_lo", found, 1'b1);
        pc_out_ready = 1'b0;
        step();
        chk("hbr_hold_code", pc_out_data[23:21], 3'b010);
        reset = 1'b0;
        #1;
        chk("hbr_async_valid", pc_out_valid, 1'b0);
        @(negedge clk);
        reset        = 1'b1;
        pc_out_ready = 1'b1;
        step();
        chk("hbr_first_valid", pc_out_valid, 1'b1);
        chk("hbr_first_data", pc_out_data, 24'h0B0B0B);
        bd_in_valid = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
